fib_ram_sequencer: RTL and testbench
====================================

Name: fib_ram_sequencer

Overview:
- Controller that sequences the shared single-port character RAM to generate a Fibonacci-style sequence.
- Seeds two RAM slots, then repeatedly reads both slots, adds them, and writes the sum back over the oldest slot.
- Sits between the slowdown unit (step tick) and the RAM port. Replaces ad-hoc sequencing logic in the top level.

Parameters:
- DATA_W, 8: RAM data width and term width.
- ADDR_W, 3: RAM address width. Only slots 0 and 1 are used; upper address bits are driven 0.
- SEED0, 1: value written to slot 0 at start.
- SEED1, 1: value written to slot 1 at start.
- MAX_TERMS, 10: number of computed terms before DONE (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a run; sampled only in IDLE or DONE
- step  in  1  pacing tick from the slowdown unit; sampled only in RD0
- ram_we  out  1  RAM write enable (combinational from state)
- ram_addr  out  ADDR_W  RAM address (combinational from state)
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data; 1-cycle synchronous read latency
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- valid  out  1  one-cycle pulse, registered; result is updated in the same cycle
- result  out  DATA_W  last computed term
- count  out  8  terms computed this run
- ovf  out  1  sticky carry-out of any addition this run

Behaviour:
- Reset is synchronous and active-high; clock is clk. Reset values:
  - state=IDLE
  - ram_we=0, ram_addr=0, ram_din=0
  - busy=0, done=0, valid=0, result=0, count=0, ovf=0
  - internal reg_a=0, reg_b=0
- Reset mid-run: next state is IDLE and ram_we=0 from the first cycle after the reset edge. No partial write completes after that edge.
- FSM states and transitions:
  - IDLE: ram_we=0. start=1 → INIT0.
  - INIT0: ram_we=1, addr=0, din=SEED0. Clear count, ovf and result. → INIT1.
  - INIT1: ram_we=1, addr=1, din=SEED1. → RD0.
  - RD0: ram_we=0, addr=0, held until step=1. On step → CAP0.
  - CAP0: addr=1. reg_a <= ram_dout (slot 0, addressed during the previous cycle). → CAP1.
  - CAP1: addr=1. reg_b <= ram_dout (slot 1). → CALC.
  - CALC: ram_we=1, addr=count[0], din=sum, where sum=(reg_a+reg_b) truncated to DATA_W.
    - Register result<=sum, count<=count+1, valid<=1 for the next cycle.
    - ovf |= carry.
    - Next state is DONE if count+1==MAX_TERMS, else RD0.
  - DONE: done=1, busy=0, ram_we=0. start=1 → INIT0 (a fresh run).
- Timing:
  - Step seen in RD0 at cycle t → write in cycle t+3 → valid=1 in cycle t+4.
  - Minimum term period is 4 cycles.
- Input handling:
  - step is ignored outside RD0; ticks arriving during CAP0, CAP1 or CALC are dropped, not queued.
  - start is ignored while busy=1.
- Write ordering: the write slot alternates 0,1,0,1… so the oldest term is always the one overwritten.
- Arithmetic: unsigned; wraps modulo 2^DATA_W. ovf is set on carry-out and stays set until the next INIT0 or reset.

Optional Feature:
- Macro: FIB_OVF_STOP_EN.
- Defined: in CALC, if the addition carries:
  - ram_we=0, so no write occurs.
  - valid is not pulsed; result and count are unchanged.
  - ovf<=1; next state is DONE.
- Undefined: the wrapped sum is written, pulsed and counted normally; ovf is flagged only.

Test Plan:
- Reset and init: rst for 2 cycles, then start=1 with step held 0 → writes slot0=1 then slot1=1 in consecutive cycles; FSM parks in RD0 with ram_we=0 and busy=1.
- Normal run, MAX_TERMS=5, one step every 10 cycles:
  - valid results 2,3,5,8,13.
  - Write slots 0,1,0,1,0.
  - done=1 after the fifth term; count=5, ovf=0.
- Pacing, step held high continuously: valid pulses exactly every 4 cycles; a step arriving mid-term produces no extra term.
- Overflow, MAX_TERMS=12, FIB_OVF_STOP_EN undefined: term 11=233, term 12=121 (377 mod 256); ovf=1; done with count=12.
- Overflow, MAX_TERMS=12, FIB_OVF_STOP_EN defined: after 233, no 12th write and no valid pulse; done=1, count=11, ovf=1, result=233.
- Abort and restart: assert rst during CAP1 → ram_we=0 and IDLE on the next cycle; a subsequent start reproduces the sequence from 2.

Source files
------------

// File: rtl/fib_ram_sequencer.sv
// Fibonacci sequencer driving a shared single-port RAM: seeds slots 0/1, then read-read-add-write per step tick.
// Optional build macro FIB_OVF_STOP_EN: a carrying addition ends the run without writing or counting that term.
module fib_ram_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int SEED0     = 1,
    parameter int SEED1     = 1,
    parameter int MAX_TERMS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic [7:0]        count,
    output logic              ovf,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT0 = 3'd1,
        S_INIT1 = 3'd2,
        S_RD0   = 3'd3,
        S_CAP0  = 3'd4,
        S_CAP1  = 3'd5,
        S_CALC  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [DATA_W-1:0] reg_b_q, reg_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [7:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic [DATA_W:0]   sum_full;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              last_term;
    logic              stop_on_carry;

    assign sum_full  = {1'b0, reg_a_q} + {1'b0, reg_b_q};
    assign sum       = sum_full[DATA_W-1:0];
    assign carry     = sum_full[DATA_W];
    assign last_term = ((count_q + 8'd1) == 8'(MAX_TERMS));

`ifdef FIB_OVF_STOP_EN
    assign stop_on_carry = carry;
`else
    assign stop_on_carry = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            result_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            result_q <= result_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        result_d = result_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT0;
            end
            S_INIT0: begin
                ram_we   = 1'b1;
                ram_din  = DATA_W'(SEED0);
                count_d  = '0;
                ovf_d    = 1'b0;
                result_d = '0;
                state_d  = S_INIT1;
            end
            S_INIT1: begin
                ram_we   = 1'b1;
                ram_addr = ADDR_W'(1);
                ram_din  = DATA_W'(SEED1);
                state_d  = S_RD0;
            end
            S_RD0: begin
                if (step) state_d = S_CAP0;
            end
            // Read data lags the address by one cycle, so CAP0 sees slot 0 while slot 1 is addressed.
            S_CAP0: begin
                ram_addr = ADDR_W'(1);
                reg_a_d  = ram_dout;
                state_d  = S_CAP1;
            end
            S_CAP1: begin
                ram_addr = ADDR_W'(1);
                reg_b_d  = ram_dout;
                state_d  = S_CALC;
            end
            S_CALC: begin
                ram_addr = ADDR_W'(count_q[0]);
                ram_din  = sum;
                ovf_d    = ovf_q | carry;
                if (stop_on_carry) begin
                    state_d = S_DONE;
                end else begin
                    ram_we   = 1'b1;
                    result_d = sum;
                    count_d  = count_q + 8'd1;
                    valid_d  = 1'b1;
                    state_d  = last_term ? S_DONE : S_RD0;
                end
            end
            S_DONE: begin
                if (start) state_d = S_INIT0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign valid     = valid_q;
    assign result    = result_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_ram_sequencer.sv
// Bench for fib_ram_sequencer: event-scheduled reference model of RAM traffic and result registers,
// checked every cycle, plus literal expectations for the Fibonacci terms and pacing.
module tb_fib_ram_sequencer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int SEED0  = 1;
    localparam int SEED1  = 1;
    localparam int MAX_T  = 12;
    localparam int BIG    = 32'h3fffffff;
`ifdef FIB_OVF_STOP_EN
    localparam bit STOP_MODE = 1'b1;
`else
    localparam bit STOP_MODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              step = 1'b0;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy, done, valid, ovf;
    logic [DATA_W-1:0] result;
    logic [7:0]        count;
    logic [2:0]        dbg_state;
    logic [DATA_W-1:0] ram_mem [0:7];

    fib_ram_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED0(SEED0), .SEED1(SEED1), .MAX_TERMS(MAX_T)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done), .valid(valid), .result(result), .count(count), .ovf(ovf),
        .dbg_state(dbg_state)
    );

    // clock / RAM
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // scoreboard state
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        bit we;
        int addr;
        int din;
        bit chk_addr;
    } bus_t;
    typedef struct {
        int cyc;
        int result;
        int count;
        int ovf;
        bit pulse;
    } reg_t;

    bus_t bus_q[$];
    reg_t reg_q[$];
    logic [DATA_W-1:0] exp_q[$];   // expected result values of pending valid pulses
    int   obs_res[$];
    int   obs_vcyc[$];

    bit m_run = 1'b0;
    bit m_final = 1'b0;
    int busy_start = 0, busy_end = 0, step_ok = 0;
    int s_count = 0, s_result = 0, s_ovf = 0;
    int a_result = 0, a_count = 0, a_ovf = 0;
    int fmem[2];

    int lit[12] = '{2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_bus(input int c, input bit we, input int addr, input int din, input bit ca);
        bus_t b;
        b.cyc = c; b.we = we; b.addr = addr; b.din = din; b.chk_addr = ca;
        bus_q.push_back(b);
    endfunction

    function automatic void push_reg(input int c, input int res, input int cnt, input int o, input bit p);
        reg_t r;
        r.cyc = c; r.result = res; r.count = cnt; r.ovf = o; r.pulse = p;
        reg_q.push_back(r);
        if (p) exp_q.push_back(DATA_W'(res));
    endfunction

    // compare process + model update, once per cycle on the falling edge
    initial begin
        bit   exp_pulse, exp_busy, exp_done, carry;
        int   sum, term;
        bus_t b;
        forever begin
            @(negedge clk);
            exp_pulse = 1'b0;
            while (reg_q.size() > 0 && reg_q[0].cyc <= cyc) begin
                a_result = reg_q[0].result;
                a_count  = reg_q[0].count;
                a_ovf    = reg_q[0].ovf;
                exp_pulse |= reg_q[0].pulse;
                void'(reg_q.pop_front());
            end
            exp_busy = m_run && cyc >= busy_start && cyc <= busy_end;
            exp_done = m_run && cyc > busy_end;
            chk("busy", int'(busy), int'(exp_busy));
            chk("done", int'(done), int'(exp_done));
            chk("valid", int'(valid), int'(exp_pulse));
            chk("result", int'(result), a_result);
            chk("count", int'(count), a_count);
            chk("ovf", int'(ovf), a_ovf);
            if (exp_pulse && exp_q.size() > 0) chk("valid_term", int'(result), int'(exp_q.pop_front()));
            if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
                b = bus_q.pop_front();
                chk("ram_we", int'(ram_we), int'(b.we));
                if (b.chk_addr) chk("ram_addr", int'(ram_addr), b.addr);
                if (b.we) chk("ram_din", int'(ram_din), b.din);
            end else begin
                chk("ram_we_idle", int'(ram_we), 0);
                if (exp_busy) chk("ram_addr_rd0", int'(ram_addr), 0);
            end
            if (valid) begin
                obs_res.push_back(int'(result));
                obs_vcyc.push_back(cyc);
            end

            // model reaction to this cycle's inputs
            if (rst) begin
                m_run = 1'b0;
                bus_q.delete(); reg_q.delete(); exp_q.delete();
                a_result = 0; a_count = 0; a_ovf = 0;
            end else if (start && !exp_busy) begin
                m_run = 1'b1; m_final = 1'b0;
                busy_start = cyc + 1; busy_end = BIG; step_ok = cyc + 3;
                push_bus(cyc + 1, 1'b1, 0, SEED0, 1'b1);
                push_bus(cyc + 2, 1'b1, 1, SEED1, 1'b1);
                push_reg(cyc + 2, 0, 0, 0, 1'b0);
                s_count = 0; s_result = 0; s_ovf = 0;
                fmem[0] = SEED0; fmem[1] = SEED1;
            end else if (step && exp_busy && !m_final && cyc >= step_ok) begin
                sum   = fmem[0] + fmem[1];
                carry = sum > 255;
                term  = sum % 256;
                push_bus(cyc + 1, 1'b0, 1, 0, 1'b1);
                push_bus(cyc + 2, 1'b0, 1, 0, 1'b1);
                if (STOP_MODE && carry) begin
                    push_bus(cyc + 3, 1'b0, 0, 0, 1'b0);
                    s_ovf = 1;
                    push_reg(cyc + 4, s_result, s_count, 1, 1'b0);
                    m_final = 1'b1; busy_end = cyc + 3;
                end else begin
                    push_bus(cyc + 3, 1'b1, s_count % 2, term, 1'b1);
                    fmem[s_count % 2] = term;
                    s_count++;
                    s_result = term;
                    if (carry) s_ovf = 1;
                    push_reg(cyc + 4, term, s_count, s_ovf, 1'b1);
                    if (s_count == MAX_T) begin
                        m_final = 1'b1; busy_end = cyc + 3;
                    end
                end
                step_ok = cyc + 4;
            end
            cyc++;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            tick(1);
            n++;
        end
        chk(name, int'(done), 1);
    endtask

    task automatic check_final_run(input string tag);
        int n_exp = STOP_MODE ? 11 : 12;
        chk({tag, "_nterms"}, obs_res.size(), n_exp);
        for (int i = 0; i < n_exp && i < obs_res.size(); i++) chk({tag, "_term"}, obs_res[i], lit[i]);
        chk({tag, "_count"}, int'(count), n_exp);
        chk({tag, "_ovf"}, int'(ovf), 1);
        chk({tag, "_result"}, int'(result), STOP_MODE ? 233 : 121);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bit seen5;
        // reset and init, FSM parks waiting for a step
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_we", int'(ram_we), 0);
        pulse_start();
        tick(6);
        chk("park_busy", int'(busy), 1);
        chk("park_we", int'(ram_we), 0);
        chk("seed_slot0", int'(ram_mem[0]), SEED0);
        chk("seed_slot1", int'(ram_mem[1]), SEED1);

        // paced run, one step every 10 cycles
        obs_res.delete(); obs_vcyc.delete();
        seen5 = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(9);
            if (obs_res.size() == 5 && !seen5) begin
                seen5 = 1'b1;
                chk("five_count", int'(count), 5);
                chk("five_ovf", int'(ovf), 0);
                chk("five_result", int'(result), 13);
            end
        end
        wait_done("paced_done", 20);
        check_final_run("paced");

        // step held high: one term every 4 cycles, mid-term ticks dropped
        obs_res.delete(); obs_vcyc.delete();
        s = cyc;
        step = 1'b1;
        pulse_start();
        wait_done("cont_done", 200);
        step = 1'b0;
        tick(2);
        if (obs_vcyc.size() > 0) chk("first_valid_latency", obs_vcyc[0] - s, 7);
        for (int i = 1; i < obs_vcyc.size(); i++) chk("period", obs_vcyc[i] - obs_vcyc[i-1], 4);
        check_final_run("cont");

        // random pacing, starts and occasional resets
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 11) == 0);
            step  = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        rst = 1'b0; start = 1'b0; step = 1'b0;

        // abort during CAP1, then restart from the seeds
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        step = 1'b1;
        pulse_start();                 // start cycle s; RD0 at s+3, CAP1 at s+5
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_we", int'(ram_we), 0);
        chk("abort_busy", int'(busy), 0);
        obs_res.delete(); obs_vcyc.delete();
        pulse_start();
        wait_done("restart_done", 200);
        step = 1'b0;
        tick(2);
        if (obs_res.size() > 0) chk("restart_first", obs_res[0], 2);
        check_final_run("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
